// File: rtl/pipelined_rca_addsub.sv
// Pipelined ripple-carry adder/subtractor with valid/ready on both sides.
// The WIDTH-bit add is cut into STAGES chunks of CHUNK bits; each stage
// resolves one chunk and registers its carry for the next stage. The
// still-unprocessed upper operand chunks travel alongside, so inputs are
// only sampled once. Each stage refills as soon as it empties, so bubbles
// collapse and a full pipe still moves one operation per clock.
// WIDTH must be an exact multiple of STAGES.
module pipelined_rca_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = WIDTH / STAGES;

  // Subtraction is a + ~b + 1, so the operand as added and the carry-in
  // are fixed here once and never revisited.
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? 1'b1 : cin;

  for (genvar k = 0; k < STAGES; k++) begin : stg
    // PW: operand bits still pending when entering stage k (chunk k and up)
    // LW: result bits resolved once stage k has loaded
    localparam int PW = WIDTH - k * CHUNK;
    localparam int LW = (k + 1) * CHUNK;

    logic          valid_q;
    logic          carry_q;
    logic [LW-1:0] sum_q;
    logic          ld;

    logic          src_valid;
    logic          src_carry;
    logic [PW-1:0] src_a;
    logic [PW-1:0] src_b;
    logic [LW-1:0] sum_next;
    logic [CHUNK:0] chunk_res;

    assign chunk_res = {1'b0, src_a[CHUNK-1:0]}
                     + {1'b0, src_b[CHUNK-1:0]}
                     + {{CHUNK{1'b0}}, src_carry};

    if (k == 0) begin : g_first
      assign src_valid = in_valid;
      assign src_carry = cin_eff;
      assign src_a     = a;
      assign src_b     = b_eff;
      assign sum_next  = chunk_res[CHUNK-1:0];
    end else begin : g_next
      assign src_valid = stg[k-1].valid_q;
      assign src_carry = stg[k-1].carry_q;
      assign src_a     = stg[k-1].g_pend.a_up_q;
      assign src_b     = stg[k-1].g_pend.b_up_q;
      assign sum_next  = {chunk_res[CHUNK-1:0], stg[k-1].sum_q};
    end

    // Stage valid, chunk carry and resolved sum bits advance whenever the stage may load
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (ld) begin
        valid_q <= src_valid;
        if (src_valid) begin
          carry_q <= chunk_res[CHUNK];
          sum_q   <= sum_next;
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic ovf_q;

      assign ld = !valid_q || out_ready;

      // Signed overflow is decided on the MSB chunk using the operand as added
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (ld && src_valid) begin
          ovf_q <= (src_a[CHUNK-1] == src_b[CHUNK-1]) &&
                   (chunk_res[CHUNK-1] != src_a[CHUNK-1]);
        end
      end
    end else begin : g_pend
      logic [PW-CHUNK-1:0] a_up_q;
      logic [PW-CHUNK-1:0] b_up_q;

      assign ld = !valid_q || stg[k+1].ld;

      // Upper operand chunks are skewed forward with their partial result
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_up_q <= '0;
          b_up_q <= '0;
        end else if (ld && src_valid) begin
          a_up_q <= src_a[PW-1:CHUNK];
          b_up_q <= src_b[PW-1:CHUNK];
        end
      end
    end
  end

  assign in_ready  = stg[0].ld;
  assign out_valid = stg[STAGES-1].valid_q;
  assign sum       = stg[STAGES-1].sum_q;
  assign cout      = stg[STAGES-1].carry_q;
  assign ovf       = stg[STAGES-1].g_last.ovf_q;

endmodule
